// File: rtl/fetch_stage.sv
// RV32 fetch stage: PC, single-outstanding imem req/ack, instruction FIFO.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_n;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_n;
  logic          r_req;
  logic          w_req_n;

  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_ack;
  logic          w_push;
  logic          w_flush;
  logic          w_discard;
  logic [CW-1:0] w_pop_ext;
  logic [CW-1:0] w_push_ext;
  logic [CW-1:0] w_cnt_after;
  logic [CW-1:0] w_cnt_left;
  logic [31:0]   w_target;

  assign w_pop       = id_valid & id_ready;
  assign w_ack       = r_req & imem_ack;
  assign w_flush     = redirect_valid;
  assign w_target    = {redirect_pc[31:2], 2'b00};
  assign w_pop_ext   = {{(CW-1){1'b0}}, w_pop};
  assign w_push_ext  = {{(CW-1){1'b0}}, w_push};
  // occupancy once this edge's push and pop are applied
  assign w_cnt_after = r_count + CW'(1) - w_pop_ext;
  assign w_cnt_left  = r_count - w_pop_ext;

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_req_n   = r_req;
    w_addr_n  = r_addr;
    w_push    = 1'b0;
    w_discard = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (w_flush) begin
          w_pc_n = w_target;
        end else if (r_count < CW'(FIFO_DEPTH)) begin
          w_req_n   = 1'b1;
          w_addr_n  = r_pc;
          w_pc_n    = r_pc + 32'd4;
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_flush) begin
          w_pc_n    = w_target;
          w_discard = 1'b1;
          if (w_ack) begin
            w_req_n   = 1'b0;
            w_state_n = S_RUN;
          end else begin
            w_state_n = S_DROP;
          end
        end else if (w_ack) begin
          w_push = 1'b1;
          if (w_cnt_after < CW'(FIFO_DEPTH)) begin
            w_req_n  = 1'b1;
            w_addr_n = r_pc;
            w_pc_n   = r_pc + 32'd4;
          end else begin
            w_req_n   = 1'b0;
            w_state_n = S_RUN;
          end
        end
      end
      S_DROP: begin
        if (w_flush) begin
          w_pc_n = w_target;
        end
        if (w_ack) begin
          w_req_n   = 1'b0;
          w_state_n = S_RUN;
        end
      end
      default: begin
        w_state_n = S_RUN;
        w_req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= 32'h0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_req   <= w_req_n;
      r_addr  <= w_addr_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + w_push_ext - w_pop_ext;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= imem_rdata;
      r_fifo_pc[r_wptr]    <= r_addr;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign id_valid  = (r_count != '0);
  assign id_instr  = id_valid ? r_fifo_instr[r_rptr] : 32'h0;
  assign id_pc     = id_valid ? r_fifo_pc[r_rptr] : 32'h0;
  assign id_opcode = id_instr[6:0];

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetched;
  logic [31:0] r_flushed;

  // flushed: entries not consumed this edge plus the in-flight word
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetched <= 32'h0;
      r_flushed <= 32'h0;
    end else begin
      if (w_push) r_fetched <= r_fetched + 32'd1;
      if (w_flush) begin
        r_flushed <= r_flushed + 32'(w_cnt_left)
                   + {31'h0, w_discard};
      end
    end
  end

  assign perf_fetched = r_fetched;
  assign perf_flushed = r_flushed;

  logic w_unused;
  assign w_unused = ^redirect_pc[1:0];
`else
  logic w_unused;
  assign w_unused = ^{redirect_pc[1:0], w_discard, w_cnt_left};
`endif

endmodule
